// File: rtl/aes_pkg.sv
// Shared AES types, S-box table and round helper functions for aes_iter_enc.
package aes_pkg;

  // Column-major state: st[c][r] is byte 4*c+r, so st[0][0] is bits [127:120].
  typedef logic [0:3][7:0]       aes_col_t;
  typedef logic [0:3][0:3][7:0]  aes_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // S-box packed MSB-first: entry v lives at bits [8*(255-v) +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int key_nk(input int kb);
    return (kb == 256) ? 8 : 4;
  endfunction

  function automatic int key_nr(input int kb);
    return (kb == 256) ? 14 : 10;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic aes_col_t mix_column(input aes_col_t a);
    aes_col_t o;
    o[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
    o[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
    o[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
    o[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
    return o;
  endfunction

  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[c][r] = s[2'(c + r)][r];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup from the aes_pkg table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] b,
  output logic [7:0] s
);

  assign s = SBOX[{~b, 3'b000} +: 8];

endmodule

// File: rtl/aes_iter_enc.sv
// Iterative AES-128/256 encryptor: one round per clock, rolling key window.
// Optional macro AES_KEY_RETAIN_EN keeps a loadable key register (key_load).
module aes_iter_enc
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        word,
  input  logic [KEY_BITS-1:0] key,
  input  logic                key_load,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        cipher
);

  // state  | meaning
  // S_IDLE | waiting for a block, in_ready=1
  // S_RUN  | one round per cycle, rnd = round being computed
  // S_DONE | cipher held, out_valid=1 until out_ready

  localparam int         NK   = key_nk(KEY_BITS);
  localparam int         NR   = key_nr(KEY_BITS);
  localparam logic [3:0] NR_L = 4'(NR);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_enc: KEY_BITS must be 128 or 256");
  end

  logic [1:0]           fsm;
  logic [3:0]           rnd;
  logic [7:0]           rcon;
  aes_state_t           st, sb, sr, mc, nxt;
  logic [0:NK-1][31:0]  kw, kw_nxt;
  logic [31:0]          sw_in, sw_out, t, n0, n1, n2, n3;
  logic [127:0]         rk;
  logic [KEY_BITS-1:0]  key_src;
  logic                 last;

  assign in_ready  = (fsm == S_IDLE);
  assign out_valid = (fsm == S_DONE);

`ifdef AES_KEY_RETAIN_EN
  logic [KEY_BITS-1:0] key_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
    end else if (fsm == S_IDLE && in_valid && key_load) begin
      key_q <= key;
    end
  end

  assign key_src = key_load ? key : key_q;
`else
  logic unused_key_load;
  assign unused_key_load = key_load;
  assign key_src = key;
`endif

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      aes_sbox u_sb (.b(st[c][r]), .s(sb[c][r]));
    end
    assign mc[c] = mix_column(sr[c]);
  end

  for (genvar k = 0; k < 4; k++) begin : g_subword
    aes_sbox u_sw (.b(sw_in[31-8*k -: 8]), .s(sw_out[31-8*k -: 8]));
  end

  // AES-256 window holds the previous and current round keys; AES-128 derives
  // the current round key combinationally from the previous one.
  if (NK == 8) begin : g_k256
    assign sw_in  = rnd[0] ? rot_word(kw[7]) : kw[7];
    assign t      = sw_out ^ (rnd[0] ? {rcon, 24'h0} : 32'h0);
    assign n0     = kw[0] ^ t;
    assign n1     = kw[1] ^ n0;
    assign n2     = kw[2] ^ n1;
    assign n3     = kw[3] ^ n2;
    assign kw_nxt = {kw[4], kw[5], kw[6], kw[7], n0, n1, n2, n3};
    assign rk     = {kw[4], kw[5], kw[6], kw[7]};
  end else begin : g_k128
    assign sw_in  = rot_word(kw[3]);
    assign t      = sw_out ^ {rcon, 24'h0};
    assign n0     = kw[0] ^ t;
    assign n1     = kw[1] ^ n0;
    assign n2     = kw[2] ^ n1;
    assign n3     = kw[3] ^ n2;
    assign kw_nxt = {n0, n1, n2, n3};
    assign rk     = {n0, n1, n2, n3};
  end

  assign sr   = shift_rows(sb);
  assign last = (rnd == NR_L);
  assign nxt  = (last ? sr : mc) ^ rk;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm    <= S_IDLE;
      rnd    <= '0;
      rcon   <= '0;
      st     <= '0;
      kw     <= '0;
      cipher <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            st   <= word ^ key_src[KEY_BITS-1 -: 128];
            kw   <= key_src;
            rnd  <= 4'd1;
            rcon <= RCON_INIT;
            fsm  <= S_RUN;
          end
        end
        S_RUN: begin
          st  <= nxt;
          kw  <= kw_nxt;
          rnd <= rnd + 4'd1;
          if (NK == 4 || rnd[0]) begin
            rcon <= xtime(rcon);
          end
          if (last) begin
            cipher <= nxt;
            fsm    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_enc.sv
// Scoreboard bench for aes_iter_enc: AES-128 and AES-256 instances side by side.
module tb_aes_iter_enc;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K_SP  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] PT_SP = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_SP = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         v128, rdy128, kl128, ov128, or128;
  logic [127:0] w128, k128, ct128;
  logic         v256, rdy256, kl256, ov256, or256;
  logic [127:0] w256, ct256;
  logic [255:0] k256;

  aes_iter_enc #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .in_valid(v128), .in_ready(rdy128), .word(w128),
    .key(k128), .key_load(kl128), .out_valid(ov128), .out_ready(or128),
    .cipher(ct128)
  );

  aes_iter_enc #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst(rst), .in_valid(v256), .in_ready(rdy256), .word(w256),
    .key(k256), .key_load(kl256), .out_valid(ov256), .out_ready(or256),
    .cipher(ct256)
  );

  int n_tot = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [127:0] exp_q128[$], exp_q256[$];
  int           acc_q128[$], acc_q256[$];
  logic         prev_ov128 = 1'b0, prev_ov256 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Latency measured from the accept edge to the first cycle out_valid is seen.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov128 && !prev_ov128) begin
        if (acc_q128.size() == 0) chk("lat128 orphan", 128'(acc_q128.size()), 128'd1);
        else chk("lat128", 128'(cyc - acc_q128.pop_front()), 128'd10);
      end
      if (ov128 && or128) begin
        if (exp_q128.size() == 0) chk("ct128 orphan", 128'(exp_q128.size()), 128'd1);
        else chk("ct128", ct128, exp_q128.pop_front());
      end
      if (ov256 && !prev_ov256) begin
        if (acc_q256.size() == 0) chk("lat256 orphan", 128'(acc_q256.size()), 128'd1);
        else chk("lat256", 128'(cyc - acc_q256.pop_front()), 128'd14);
      end
      if (ov256 && or256) begin
        if (exp_q256.size() == 0) chk("ct256 orphan", 128'(exp_q256.size()), 128'd1);
        else chk("ct256", ct256, exp_q256.pop_front());
      end
    end
    prev_ov128 = ov128;
    prev_ov256 = ov256;
  end

  task automatic send(input bit big, input string tag, input logic [127:0] w,
                      input logic [255:0] k, input logic kl, input logic [127:0] exp,
                      output int acc);
    bit ok = 1'b0;
    acc = -1;
    @(negedge clk);
    if (big) begin v256 = 1'b1; w256 = w; k256 = k; kl256 = kl; end
    else begin v128 = 1'b1; w128 = w; k128 = k[255:128]; kl128 = kl; end
    for (int i = 0; i < 64; i++) begin
      ok = big ? rdy256 : rdy128;
      if (ok) break;
      @(negedge clk);
    end
    chk(tag, 128'(ok), 128'd1);
    if (ok) begin
      acc = cyc + 1;
      if (big) begin exp_q256.push_back(exp); acc_q256.push_back(acc); end
      else begin exp_q128.push_back(exp); acc_q128.push_back(acc); end
      @(posedge clk);
      #1;
    end
    if (big) v256 = 1'b0;
    else v128 = 1'b0;
  endtask

  task automatic drain(input bit big, input string tag);
    int n = 0;
    while ((big ? exp_q256.size() : exp_q128.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(big ? exp_q256.size() : exp_q128.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a1, a2, n;
    rst = 1'b1;
    v128 = 1'b0; w128 = '0; k128 = '0; kl128 = 1'b1; or128 = 1'b1;
    v256 = 1'b0; w256 = '0; k256 = '0; kl256 = 1'b1; or256 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rdy128", 128'(rdy128), 128'd1);
    chk("rst ov128",  128'(ov128),  128'd0);
    chk("rst ct128",  ct128,        128'd0);
    chk("rst rdy256", 128'(rdy256), 128'd1);
    chk("rst ov256",  128'(ov256),  128'd0);
    chk("rst ct256",  ct256,        128'd0);
    rst = 1'b0;

    send(1'b0, "acc c1", PT, {K_C1, 128'h0}, 1'b1, CT_C1, a1);
    drain(1'b0, "drain c1");
    send(1'b1, "acc c3", PT, K_C3, 1'b1, CT_C3, a1);
    drain(1'b1, "drain c3");

    // Backpressure: result must be held with in_ready low.
    or128 = 1'b0;
    send(1'b0, "acc bp", PT_B, {K_B, 128'h0}, 1'b1, CT_B, a1);
    n = 0;
    while (!ov128 && n < 40) begin @(negedge clk); n++; end
    chk("bp ov", 128'(ov128), 128'd1);
    repeat (20) begin
      @(negedge clk);
      chk("bp ct",  ct128,         CT_B);
      chk("bp rdy", 128'(rdy128),  128'd0);
      chk("bp ov hold", 128'(ov128), 128'd1);
    end
    @(posedge clk); #1 or128 = 1'b1;
    @(posedge clk); #1 or128 = 1'b0;
    @(negedge clk);
    chk("bp rdy after", 128'(rdy128), 128'd1);
    chk("bp ov after",  128'(ov128),  128'd0);
    chk("bp ct keep",   ct128,        CT_B);
    chk("bp popped",    128'(exp_q128.size()), 128'd0);
    or128 = 1'b1;

    // Reset lands on the round-5 edge.
    send(1'b0, "acc rst", PT, {K_C1, 128'h0}, 1'b1, CT_C1, a1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q128.delete();
    acc_q128.delete();
    @(negedge clk);
    chk("mid rst ov", 128'(ov128),  128'd0);
    chk("mid rst ct", ct128,        128'd0);
    chk("mid rst rdy", 128'(rdy128), 128'd1);
    send(1'b0, "acc after rst", PT, {K_C1, 128'h0}, 1'b1, CT_C1, a1);
    drain(1'b0, "drain after rst");

    send(1'b0, "b2b128 a", PT,   {K_C1, 128'h0}, 1'b1, CT_C1, a1);
    send(1'b0, "b2b128 b", PT_B, {K_B, 128'h0},  1'b1, CT_B,  a2);
    drain(1'b0, "drain b2b128");
    chk("period128", 128'(a2 - a1), 128'd12);

    send(1'b1, "b2b256 a", PT,    K_C3, 1'b1, CT_C3, a1);
    send(1'b1, "b2b256 b", PT_SP, K_SP, 1'b1, CT_SP, a2);
    drain(1'b1, "drain b2b256");
    chk("period256", 128'(a2 - a1), 128'd16);

`ifdef AES_KEY_RETAIN_EN
    send(1'b1, "ret load", PT, K_C3,   1'b1, CT_C3, a1);
    send(1'b1, "ret reuse", PT, 256'h0, 1'b0, CT_C3, a2);
    drain(1'b1, "drain ret");
`else
    send(1'b1, "kl0 a", PT,    K_C3, 1'b0, CT_C3, a1);
    send(1'b1, "kl0 b", PT_SP, K_SP, 1'b0, CT_SP, a2);
    drain(1'b1, "drain kl0");
`endif

    repeat (3) @(negedge clk);
    chk("q128 empty", 128'(acc_q128.size()), 128'd0);
    chk("q256 empty", 128'(acc_q256.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
